// File: rtl/hls_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module      : hls_activity_monitor
// Description : Passive tap that counts kernel transactions, latency, and
//               sequential/pipelined loop activity for one HLS kernel.
// Revision    : 1.0 - initial release
// ============================================================================
module hls_activity_monitor #(
    parameter int STATE_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               finish,
    input  logic               mod_start,
    input  logic               mod_done,
    input  logic               mod_continue,
    input  logic [STATE_W-1:0] seq_cur_state,
    input  logic [STATE_W-1:0] seq_iter_start_state,
    input  logic [STATE_W-1:0] seq_iter_end_state,
    input  logic [STATE_W-1:0] upc_cur_state,
    input  logic [STATE_W-1:0] upc_iter_start_state,
    input  logic [STATE_W-1:0] upc_iter_end_state,
    input  logic               upc_iter_start_block,
    input  logic               upc_iter_end_block,
    input  logic               upc_iter_start_enable,
    input  logic               upc_iter_end_enable,
    input  logic               upc_loop_start,
    input  logic               upc_loop_done,
    output logic               mod_busy,
    output logic [CNT_W-1:0]   mod_txn_count,
    output logic [CNT_W-1:0]   mod_last_latency,
    output logic [CNT_W-1:0]   mod_max_latency,
    output logic               seq_in_loop,
    output logic [CNT_W-1:0]   seq_loop_count,
    output logic [CNT_W-1:0]   seq_iter_count,
    output logic               upc_active,
    output logic [CNT_W-1:0]   upc_loop_count,
    output logic [CNT_W-1:0]   upc_iter_start_count,
    output logic [CNT_W-1:0]   upc_iter_end_count,
    output logic               frozen
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : v + c_CNT_ONE;
    endfunction

    logic               busy_q,      busy_d;
    logic [CNT_W-1:0]   timer_q,     timer_d;
    logic [CNT_W-1:0]   txn_q,       txn_d;
    logic [CNT_W-1:0]   last_q,      last_d;
    logic [CNT_W-1:0]   max_q,       max_d;
    logic [STATE_W-1:0] prev_q,      prev_d;
    logic               in_loop_q,   in_loop_d;
    logic [CNT_W-1:0]   sloop_q,     sloop_d;
    logic [CNT_W-1:0]   siter_q,     siter_d;
    logic               active_q,    active_d;
    logic [CNT_W-1:0]   uloop_q,     uloop_d;
    logic [CNT_W-1:0]   ustart_q,    ustart_d;
    logic [CNT_W-1:0]   uend_q,      uend_d;
    logic               frozen_q,    frozen_d;

    logic               w_start_now;
    logic               w_complete;
    logic [CNT_W-1:0]   w_latency;
    logic               w_cur_is_start;
    logic               w_cur_is_end;
    logic               w_prev_is_start;
    logic               w_prev_is_end;
    logic               w_single_state;
    logic               w_seq_entry;
    logic               w_seq_iter;
    logic               w_seq_exit;
    logic               w_upc_issue;
    logic               w_upc_retire;

    assign w_start_now = mod_start & ~busy_q;
    assign w_complete  = mod_done & mod_continue & (busy_q | mod_start);
    // Latency includes the current cycle; a same-cycle start/done reports 1.
    assign w_latency   = busy_q ? sat_inc(timer_q) : c_CNT_ONE;

    assign w_cur_is_start  = (seq_cur_state == seq_iter_start_state);
    assign w_cur_is_end    = (seq_cur_state == seq_iter_end_state);
    assign w_prev_is_start = (prev_q == seq_iter_start_state);
    assign w_prev_is_end   = (prev_q == seq_iter_end_state);
    assign w_single_state  = (seq_iter_start_state == seq_iter_end_state);

    assign w_seq_entry = w_cur_is_start & ~w_prev_is_start & ~w_prev_is_end;
    assign w_seq_iter  = (w_prev_is_end & ~w_cur_is_end)
                       | (w_single_state & w_prev_is_start & w_cur_is_start);
    assign w_seq_exit  = w_prev_is_end & ~w_cur_is_start;

    assign w_upc_issue  = (upc_cur_state == upc_iter_start_state)
                        & ~upc_iter_start_block & upc_iter_start_enable;
    assign w_upc_retire = (upc_cur_state == upc_iter_end_state)
                        & ~upc_iter_end_block & upc_iter_end_enable;

    always_comb begin
        busy_d    = busy_q;
        timer_d   = timer_q;
        txn_d     = txn_q;
        last_d    = last_q;
        max_d     = max_q;
        prev_d    = prev_q;
        in_loop_d = in_loop_q;
        sloop_d   = sloop_q;
        siter_d   = siter_q;
        active_d  = active_q;
        uloop_d   = uloop_q;
        ustart_d  = ustart_q;
        uend_d    = uend_q;
        frozen_d  = frozen_q;

        if (clear) begin
            busy_d    = 1'b0;
            timer_d   = '0;
            txn_d     = '0;
            last_d    = '0;
            max_d     = '0;
            prev_d    = '0;
            in_loop_d = 1'b0;
            sloop_d   = '0;
            siter_d   = '0;
            active_d  = 1'b0;
            uloop_d   = '0;
            ustart_d  = '0;
            uend_d    = '0;
            frozen_d  = 1'b0;
        end else if (!frozen_q) begin
            if (w_complete) begin
                txn_d  = sat_inc(txn_q);
                last_d = w_latency;
                if (w_latency > max_q) begin
                    max_d = w_latency;
                end
                // Back-to-back: a start alongside completion of a running txn restarts.
                busy_d  = busy_q & mod_start;
                timer_d = c_CNT_ONE;
            end else if (w_start_now) begin
                busy_d  = 1'b1;
                timer_d = c_CNT_ONE;
            end else if (busy_q) begin
                timer_d = sat_inc(timer_q);
            end

            prev_d = seq_cur_state;
            if (w_seq_entry) begin
                sloop_d   = sat_inc(sloop_q);
                in_loop_d = 1'b1;
            end
            if (w_seq_iter) begin
                siter_d = sat_inc(siter_q);
            end
            if (w_seq_exit) begin
                in_loop_d = 1'b0;
            end

            if (w_upc_issue) begin
                ustart_d = sat_inc(ustart_q);
            end
            if (w_upc_retire) begin
                uend_d = sat_inc(uend_q);
            end
            active_d = upc_loop_start | (active_q & ~upc_loop_done);
            if (upc_loop_done) begin
                uloop_d = sat_inc(uloop_q);
            end

            if (finish) begin
                frozen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            timer_q   <= '0;
            txn_q     <= '0;
            last_q    <= '0;
            max_q     <= '0;
            prev_q    <= '0;
            in_loop_q <= 1'b0;
            sloop_q   <= '0;
            siter_q   <= '0;
            active_q  <= 1'b0;
            uloop_q   <= '0;
            ustart_q  <= '0;
            uend_q    <= '0;
            frozen_q  <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            timer_q   <= timer_d;
            txn_q     <= txn_d;
            last_q    <= last_d;
            max_q     <= max_d;
            prev_q    <= prev_d;
            in_loop_q <= in_loop_d;
            sloop_q   <= sloop_d;
            siter_q   <= siter_d;
            active_q  <= active_d;
            uloop_q   <= uloop_d;
            ustart_q  <= ustart_d;
            uend_q    <= uend_d;
            frozen_q  <= frozen_d;
        end
    end

    assign mod_busy             = busy_q;
    assign mod_txn_count        = txn_q;
    assign mod_last_latency     = last_q;
    assign mod_max_latency      = max_q;
    assign seq_in_loop          = in_loop_q;
    assign seq_loop_count       = sloop_q;
    assign seq_iter_count       = siter_q;
    assign upc_active           = active_q;
    assign upc_loop_count       = uloop_q;
    assign upc_iter_start_count = ustart_q;
    assign upc_iter_end_count   = uend_q;
    assign frozen               = frozen_q;

endmodule
`default_nettype wire

// File: tb/tb_hls_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_hls_activity_monitor
// Description : Directed and randomized checks of hls_activity_monitor
//               against a cycle-stamp based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hls_activity_monitor;

    localparam int    SW   = 6;
    localparam int    CW   = 5;
    localparam longint MAXV = (64'd1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset, clear, finish;
    logic          mod_start, mod_done, mod_continue;
    logic [SW-1:0] seq_cur_state, seq_iter_start_state, seq_iter_end_state;
    logic [SW-1:0] upc_cur_state, upc_iter_start_state, upc_iter_end_state;
    logic          upc_iter_start_block, upc_iter_end_block;
    logic          upc_iter_start_enable, upc_iter_end_enable;
    logic          upc_loop_start, upc_loop_done;
    logic          mod_busy, seq_in_loop, upc_active, frozen;
    logic [CW-1:0] mod_txn_count, mod_last_latency, mod_max_latency;
    logic [CW-1:0] seq_loop_count, seq_iter_count;
    logic [CW-1:0] upc_loop_count, upc_iter_start_count, upc_iter_end_count;

    hls_activity_monitor #(.STATE_W(SW), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .clear(clear), .finish(finish),
        .mod_start(mod_start), .mod_done(mod_done), .mod_continue(mod_continue),
        .seq_cur_state(seq_cur_state),
        .seq_iter_start_state(seq_iter_start_state),
        .seq_iter_end_state(seq_iter_end_state),
        .upc_cur_state(upc_cur_state),
        .upc_iter_start_state(upc_iter_start_state),
        .upc_iter_end_state(upc_iter_end_state),
        .upc_iter_start_block(upc_iter_start_block),
        .upc_iter_end_block(upc_iter_end_block),
        .upc_iter_start_enable(upc_iter_start_enable),
        .upc_iter_end_enable(upc_iter_end_enable),
        .upc_loop_start(upc_loop_start), .upc_loop_done(upc_loop_done),
        .mod_busy(mod_busy), .mod_txn_count(mod_txn_count),
        .mod_last_latency(mod_last_latency), .mod_max_latency(mod_max_latency),
        .seq_in_loop(seq_in_loop), .seq_loop_count(seq_loop_count),
        .seq_iter_count(seq_iter_count), .upc_active(upc_active),
        .upc_loop_count(upc_loop_count),
        .upc_iter_start_count(upc_iter_start_count),
        .upc_iter_end_count(upc_iter_end_count), .frozen(frozen)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: latency from cycle stamps, counters as plain saturating integers.
    longint m_cyc, m_start_cyc;
    longint m_busy, m_txn, m_last, m_max, m_prev, m_in, m_sloop, m_siter;
    longint m_act, m_uloop, m_us, m_ue, m_frozen;

    function automatic longint sat(input longint v);
        return (v + 1 > MAXV) ? MAXV : v + 1;
    endfunction

    task automatic m_zero();
        m_busy = 0; m_start_cyc = 0; m_txn = 0; m_last = 0; m_max = 0;
        m_prev = 0; m_in = 0; m_sloop = 0; m_siter = 0;
        m_act = 0; m_uloop = 0; m_us = 0; m_ue = 0; m_frozen = 0;
    endtask

    task automatic model_step();
        longint lat, c, s, e;
        m_cyc++;
        if (!reset || clear) begin
            m_zero();
        end else if (m_frozen == 0) begin
            if (mod_done && mod_continue && (m_busy != 0 || mod_start)) begin
                lat = (m_busy != 0) ? m_cyc - m_start_cyc + 1 : 1;
                if (lat > MAXV) lat = MAXV;
                m_txn  = sat(m_txn);
                m_last = lat;
                if (lat > m_max) m_max = lat;
                if (m_busy != 0 && mod_start) m_start_cyc = m_cyc;
                else m_busy = 0;
            end else if (mod_start && m_busy == 0) begin
                m_busy = 1;
                m_start_cyc = m_cyc;
            end
            c = longint'(seq_cur_state);
            s = longint'(seq_iter_start_state);
            e = longint'(seq_iter_end_state);
            if (c == s && m_prev != s && m_prev != e) begin
                m_sloop = sat(m_sloop);
                m_in = 1;
            end
            if ((m_prev == e && c != e) || (s == e && m_prev == s && c == s))
                m_siter = sat(m_siter);
            if (m_prev == e && c != s) m_in = 0;
            m_prev = c;
            if (upc_cur_state == upc_iter_start_state && !upc_iter_start_block && upc_iter_start_enable)
                m_us = sat(m_us);
            if (upc_cur_state == upc_iter_end_state && !upc_iter_end_block && upc_iter_end_enable)
                m_ue = sat(m_ue);
            if (upc_loop_done) begin
                m_uloop = sat(m_uloop);
                m_act = upc_loop_start ? 1 : 0;
            end else if (upc_loop_start) begin
                m_act = 1;
            end
            if (finish) m_frozen = 1;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle_inputs();
        clear = 0; finish = 0;
        mod_start = 0; mod_done = 0; mod_continue = 1;
        seq_cur_state = 0; seq_iter_start_state = 3; seq_iter_end_state = 6;
        upc_cur_state = 0; upc_iter_start_state = 5; upc_iter_end_state = 5;
        upc_iter_start_block = 0; upc_iter_end_block = 0;
        upc_iter_start_enable = 0; upc_iter_end_enable = 0;
        upc_loop_start = 0; upc_loop_done = 0;
    endtask

    task automatic rand_inputs();
        clear  = ($urandom_range(0, 119) == 0);
        finish = ($urandom_range(0, 249) == 0);
        mod_start    = ($urandom_range(0, 3) == 0);
        mod_done     = ($urandom_range(0, 2) == 0);
        mod_continue = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 0) seq_cur_state = SW'($urandom_range(0, 6));
        upc_cur_state = SW'($urandom_range(0, 3));
        upc_iter_start_block  = ($urandom_range(0, 3) == 0);
        upc_iter_end_block    = ($urandom_range(0, 3) == 0);
        upc_iter_start_enable = ($urandom_range(0, 3) != 0);
        upc_iter_end_enable   = ($urandom_range(0, 3) != 0);
        upc_loop_start = ($urandom_range(0, 7) == 0);
        upc_loop_done  = ($urandom_range(0, 7) == 0);
    endtask

    function automatic logic any_output();
        return mod_busy | seq_in_loop | upc_active | frozen
             | (|mod_txn_count) | (|mod_last_latency) | (|mod_max_latency)
             | (|seq_loop_count) | (|seq_iter_count) | (|upc_loop_count)
             | (|upc_iter_start_count) | (|upc_iter_end_count);
    endfunction

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("mod_busy",  longint'(mod_busy),         m_busy);
            chk("txn_count", longint'(mod_txn_count),    m_txn);
            chk("last_lat",  longint'(mod_last_latency), m_last);
            chk("max_lat",   longint'(mod_max_latency),  m_max);
            chk("seq_in",    longint'(seq_in_loop),      m_in);
            chk("seq_loop",  longint'(seq_loop_count),   m_sloop);
            chk("seq_iter",  longint'(seq_iter_count),   m_siter);
            chk("upc_act",   longint'(upc_active),       m_act);
            chk("upc_loop",  longint'(upc_loop_count),   m_uloop);
            chk("upc_start", longint'(upc_iter_start_count), m_us);
            chk("upc_end",   longint'(upc_iter_end_count),   m_ue);
            chk("frozen",    longint'(frozen),           m_frozen);
        end
    end

    initial begin
        m_cyc = 0;
        m_zero();
        reset = 0;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            tick();
        end
        chk("rst_outputs_zero", longint'(any_output()), 0);
        idle_inputs();
        reset = 1;
        ticks(5);
        chk("idle_outputs_zero", longint'(any_output()), 0);

        // Kernel: 10-cycle then 4-cycle transaction.
        clear = 1; tick(); clear = 0;
        mod_start = 1; tick(); mod_start = 0;
        ticks(8);
        mod_done = 1; tick(); mod_done = 0;
        chk("k1_txn",  longint'(mod_txn_count), 1);
        chk("k1_last", longint'(mod_last_latency), 10);
        chk("k1_max",  longint'(mod_max_latency), 10);
        chk("k1_model_last", m_last, 10);
        mod_start = 1; tick(); mod_start = 0;
        ticks(2);
        mod_done = 1; tick(); mod_done = 0;
        chk("k2_last", longint'(mod_last_latency), 4);
        chk("k2_max",  longint'(mod_max_latency), 10);
        chk("k2_busy", longint'(mod_busy), 0);
        // Held done without continue keeps busy.
        mod_start = 1; tick(); mod_start = 0;
        mod_done = 1; mod_continue = 0; tick();
        chk("hold_busy", longint'(mod_busy), 1);
        mod_continue = 1; tick(); mod_done = 0;
        chk("hold_last", longint'(mod_last_latency), 3);

        // Back-to-back completion and restart.
        clear = 1; tick(); clear = 0;
        mod_start = 1; tick(); tick();
        mod_done = 1; tick();
        chk("b2b_busy", longint'(mod_busy), 1);
        chk("b2b_last", longint'(mod_last_latency), 3);
        mod_start = 0; tick(); mod_done = 0;
        chk("b2b_last2", longint'(mod_last_latency), 2);
        chk("b2b_txn",   longint'(mod_txn_count), 2);

        // Sequential loop 2,3,4,5,6,3,4,5,6,1.
        clear = 1; tick(); clear = 0;
        seq_iter_start_state = 3; seq_iter_end_state = 6;
        foreach (dut.seq_cur_state[i]) begin end
        begin
            int seqv[10] = '{2, 3, 4, 5, 6, 3, 4, 5, 6, 1};
            for (int i = 0; i < 10; i++) begin
                seq_cur_state = SW'(seqv[i]);
                tick();
                if (i == 1) chk("seq_in_mid", longint'(seq_in_loop), 1);
            end
        end
        chk("seq_loop", longint'(seq_loop_count), 1);
        chk("seq_iter", longint'(seq_iter_count), 2);
        chk("seq_out",  longint'(seq_in_loop), 0);
        // One-state loop: 4 cycles in state 7 then out.
        seq_iter_start_state = 7; seq_iter_end_state = 7;
        seq_cur_state = 7; ticks(4);
        seq_cur_state = 0; tick();
        chk("seq1_iter", longint'(seq_iter_count), 6);
        chk("seq1_loop", longint'(seq_loop_count), 2);

        // Pipelined loop, II=1, one stalled cycle.
        clear = 1; tick(); clear = 0;
        upc_loop_start = 1; tick(); upc_loop_start = 0;
        chk("upc_act_on", longint'(upc_active), 1);
        upc_cur_state = 5; upc_iter_start_enable = 1; upc_iter_end_enable = 1;
        for (int i = 0; i < 6; i++) begin
            upc_iter_start_block = (i == 3);
            upc_iter_end_block   = (i == 3);
            tick();
        end
        upc_iter_start_block = 0; upc_iter_end_block = 0;
        upc_iter_start_enable = 0; upc_iter_end_enable = 0;
        chk("upc_start5", longint'(upc_iter_start_count), 5);
        chk("upc_end5",   longint'(upc_iter_end_count), 5);
        upc_loop_done = 1; tick(); upc_loop_done = 0;
        chk("upc_loop1", longint'(upc_loop_count), 1);
        chk("upc_act_off", longint'(upc_active), 0);

        // Freeze: counting still happens in the finish cycle.
        finish = 1; upc_iter_start_enable = 1; upc_iter_end_enable = 1; tick();
        finish = 0; mod_start = 1; upc_loop_done = 1;
        seq_iter_start_state = 3; seq_iter_end_state = 6; seq_cur_state = 3;
        ticks(3);
        chk("frz_flag",  longint'(frozen), 1);
        chk("frz_start", longint'(upc_iter_start_count), 6);
        chk("frz_end",   longint'(upc_iter_end_count), 6);
        chk("frz_busy",  longint'(mod_busy), 0);
        chk("frz_loop",  longint'(upc_loop_count), 1);
        idle_inputs();
        clear = 1; tick(); clear = 0;
        chk("clr_zero", longint'(any_output()), 0);

        // Randomized phase with occasional asynchronous reset.
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                seq_iter_start_state = SW'($urandom_range(1, 4));
                seq_iter_end_state   = ($urandom_range(0, 3) == 0) ? seq_iter_start_state
                                                                    : SW'($urandom_range(1, 6));
                upc_iter_start_state = SW'($urandom_range(0, 3));
                upc_iter_end_state   = SW'($urandom_range(0, 3));
            end
            rand_inputs();
            if ($urandom_range(0, 499) == 0) begin
                reset = 0;
                m_zero();
            end else begin
                reset = 1;
            end
            tick();
        end

        cmp_en = 0;
        @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
